pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (IF, DEC, EXE, MEM, WB).
- Merges three hazard sources into one coherent set of per-stage stall and flush controls:
  - branch resolution in EXE,
  - load-use dependences between EXE and DEC,
  - multi-cycle memory waits in MEM.
- Fetch consumes jump/target_pc_out. Pipeline registers consume the stall/flush outputs.
- Also keeps saturating performance counters.

---
 rtl/pipe_hazard_ctrl_if.sv | 44 ++++
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline and its central stall/flush sequencer.
// The master side is the pipeline: it reports hazard sources and consumes stall, flush and redirect controls.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       dec_rs1;
  logic [4:0]       dec_rs2;
  logic             dec_uses_rs1;
  logic             dec_uses_rs2;
  logic             exe_is_load;
  logic [4:0]       exe_rd;
  logic             exe_is_branch;
  logic             z_flag;
  logic [31:0]      target_pc_in;
  logic             mem_req;
  logic             mem_ready;

  logic             jump;
  logic [31:0]      target_pc_out;
  logic             pc_stall;
  logic             dec_stall;
  logic             exe_stall;
  logic             mem_stall;
  logic             dec_flush;
  logic             exe_flush;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] taken_branches;

  modport master (
    output dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
    output exe_is_load, exe_rd, exe_is_branch, z_flag, target_pc_in,
    output mem_req, mem_ready,
    input  jump, target_pc_out, pc_stall, dec_stall, exe_stall, mem_stall,
    input  dec_flush, exe_flush, stall_cycles, taken_branches
  );

  modport slave (
    input  dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
    input  exe_is_load, exe_rd, exe_is_branch, z_flag, target_pc_in,
    input  mem_req, mem_ready,
    output jump, target_pc_out, pc_stall, dec_stall, exe_stall, mem_stall,
    output dec_flush, exe_flush, stall_cycles, taken_branches
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: merges memory-wait, branch and load-use hazards
// (in that priority) into per-stage controls, plus saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    BR_SHADOW = 2'd1,
    LU_STALL  = 2'd2,
    MEM_WAIT  = 2'd3
  } state_e;

  localparam logic [2:0] LU_INIT = 3'(LU_BUBBLES - 1);

  state_e           state_q, state_d;
  state_e           ret_state_q, ret_state_d;
  logic [2:0]       lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic lu_hit, br_taken, mem_wait, mem_wait_entry;
  logic jump_c, pc_stall_c, dec_stall_c, exe_stall_c, mem_stall_c, dec_flush_c, exe_flush_c;

  assign lu_hit = hz.exe_is_load && (hz.exe_rd != 5'd0) &&
                  ((hz.dec_uses_rs1 && (hz.dec_rs1 == hz.exe_rd)) ||
                   (hz.dec_uses_rs2 && (hz.dec_rs2 == hz.exe_rd)));
  assign br_taken       = hz.exe_is_branch && hz.z_flag;
  // A dropped mem_req counts as completion, so only an outstanding, unready access waits.
  assign mem_wait       = hz.mem_req && !hz.mem_ready;
  assign mem_wait_entry = (state_q != MEM_WAIT) && mem_wait;

  // NOTE: state and counters use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      ret_state_q <= RUN;
      lu_cnt_q    <= '0;
      stall_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
      lu_cnt_q    <= lu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    ret_state_d = ret_state_q;
    lu_cnt_d    = lu_cnt_q;
    if (mem_wait_entry) begin
      ret_state_d = state_q;
      state_d     = MEM_WAIT;
    end else begin
      case (state_q)
        RUN: begin
          if (hz.exe_is_branch) begin
            state_d = BR_SHADOW;
          end else if (lu_hit) begin
            lu_cnt_d = LU_INIT;
            state_d  = (LU_BUBBLES > 1) ? LU_STALL : RUN;
          end
        end
        BR_SHADOW: state_d = RUN;
        LU_STALL: begin
          lu_cnt_d = lu_cnt_q - 3'd1;
          if (lu_cnt_q <= 3'd1) state_d = RUN;
        end
        MEM_WAIT: if (!mem_wait) state_d = ret_state_q;
        default:  state_d = RUN;
      endcase
    end
  end

  always_comb begin
    jump_c      = 1'b0;
    pc_stall_c  = 1'b0;
    dec_stall_c = 1'b0;
    exe_stall_c = 1'b0;
    mem_stall_c = 1'b0;
    dec_flush_c = 1'b0;
    exe_flush_c = 1'b0;
    if (mem_wait_entry || (state_q == MEM_WAIT && mem_wait)) begin
      pc_stall_c  = 1'b1;
      dec_stall_c = 1'b1;
      exe_stall_c = 1'b1;
      mem_stall_c = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (br_taken) begin
            jump_c      = 1'b1;
            dec_flush_c = 1'b1;
            exe_flush_c = 1'b1;
          end else if (!hz.exe_is_branch && lu_hit) begin
            pc_stall_c  = 1'b1;
            dec_stall_c = 1'b1;
            exe_flush_c = 1'b1;
          end
        end
        BR_SHADOW: exe_flush_c = 1'b1;
        LU_STALL: begin
          pc_stall_c  = 1'b1;
          dec_stall_c = 1'b1;
          exe_flush_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (pc_stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (jump_c && (taken_cnt_q != '1))     taken_cnt_d = taken_cnt_q + CNT_W'(1);
  end

  // Controls are gated by rst_n so the pipeline sees no stall or flush while reset is held.
  assign hz.jump           = rst_n && jump_c;
  assign hz.pc_stall       = rst_n && pc_stall_c;
  assign hz.dec_stall      = rst_n && dec_stall_c;
  assign hz.exe_stall      = rst_n && exe_stall_c;
  assign hz.mem_stall      = rst_n && mem_stall_c;
  assign hz.dec_flush      = rst_n && dec_flush_c;
  assign hz.exe_flush      = rst_n && exe_flush_c;
  assign hz.target_pc_out  = hz.target_pc_in;
  assign hz.stall_cycles   = stall_cnt_q;
  assign hz.taken_branches = taken_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios plus random
// stimulus, all compared against a behavioural model of the sequencing rules.
module tb_pipe_hazard_ctrl;

  localparam int LU = 3;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) hz ();

  pipe_hazard_ctrl #(.LU_BUBBLES(LU), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a memory wait freezes all progress; otherwise a pending shadow cycle,
  // then remaining load-use bubbles, then new branch / load-use hazards.
  bit m_waiting, m_shadow;
  int m_bubbles, m_stalls, m_taken;
  bit n_waiting, n_shadow;
  int n_bubbles, n_stalls, n_taken;
  logic [31:0] tpc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_waiting = 0; m_shadow = 0; m_bubbles = 0; m_stalls = 0; m_taken = 0;
  endtask

  // e = {jump, pc_stall, dec_stall, exe_stall, mem_stall, dec_flush, exe_flush}
  task automatic model_eval(output logic [6:0] e);
    bit mw, hit;
    mw  = hz.mem_req && !hz.mem_ready;
    hit = hz.exe_is_load && hz.exe_rd != 0 &&
          ((hz.dec_uses_rs1 && hz.dec_rs1 == hz.exe_rd) ||
           (hz.dec_uses_rs2 && hz.dec_rs2 == hz.exe_rd));
    n_waiting = m_waiting; n_shadow = m_shadow; n_bubbles = m_bubbles;
    n_stalls = m_stalls; n_taken = m_taken;
    e = 7'b0;
    if (m_waiting) begin
      if (mw) e = 7'b0111100;
      n_waiting = mw;
    end else if (mw) begin
      e = 7'b0111100;
      n_waiting = 1;
    end else if (m_shadow) begin
      e = 7'b0000001;
      n_shadow = 0;
    end else if (m_bubbles > 0) begin
      e = 7'b0110001;
      n_bubbles = m_bubbles - 1;
    end else if (hz.exe_is_branch) begin
      if (hz.z_flag) begin
        e = 7'b1000011;
        if (n_taken < CNT_MAX) n_taken++;
      end
      n_shadow = 1;
    end else if (hit) begin
      e = 7'b0110001;
      n_bubbles = LU - 1;
    end
    if (e[5] && n_stalls < CNT_MAX) n_stalls++;
  endtask

  task automatic set_idle();
    hz.dec_rs1 = 0; hz.dec_rs2 = 0; hz.dec_uses_rs1 = 0; hz.dec_uses_rs2 = 0;
    hz.exe_is_load = 0; hz.exe_rd = 0; hz.exe_is_branch = 0; hz.z_flag = 0;
    tpc = 32'h0; hz.target_pc_in = tpc; hz.mem_req = 0; hz.mem_ready = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    hz.exe_is_load = 1; hz.exe_rd = rd; hz.dec_rs2 = 5'd5; hz.dec_uses_rs2 = 1;
  endtask

  // Called just after a negedge with inputs applied; returns just after the next negedge.
  task automatic run_cycle(input string tag);
    logic [6:0] e;
    hz.target_pc_in = tpc;
    #1;
    model_eval(e);
    check({tag, ".ctl"}, {hz.jump, hz.pc_stall, hz.dec_stall, hz.exe_stall,
                          hz.mem_stall, hz.dec_flush, hz.exe_flush}, e);
    check({tag, ".tpc"}, hz.target_pc_out, tpc);
    @(posedge clk);
    m_waiting = n_waiting; m_shadow = n_shadow; m_bubbles = n_bubbles;
    m_stalls = n_stalls; m_taken = n_taken;
    #1;
    check({tag, ".stall_cnt"}, hz.stall_cycles, m_stalls);
    check({tag, ".taken_cnt"}, hz.taken_branches, m_taken);
    @(negedge clk);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, ".ctl"}, {hz.jump, hz.pc_stall, hz.dec_stall, hz.exe_stall,
                          hz.mem_stall, hz.dec_flush, hz.exe_flush}, 7'b0);
    check({tag, ".stall_cnt"}, hz.stall_cycles, 0);
    check({tag, ".taken_cnt"}, hz.taken_branches, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    set_idle();
    model_reset();
    @(negedge clk);
    apply_reset("reset_init");

    // Reset in the middle of a load-use stall clears state and counters at once.
    set_load_use(5'd5);
    run_cycle("lu_enter");
    set_idle();
    run_cycle("lu_stall");
    apply_reset("reset_mid_lu");
    run_cycle("post_reset_idle");

    // Taken branch: redirect and flush, then one shadow cycle.
    hz.exe_is_branch = 1; hz.z_flag = 1; tpc = 32'h0000_0040;
    run_cycle("br_taken");
    set_idle();
    run_cycle("br_shadow");
    check("br_taken.count", hz.taken_branches, 1);
    run_cycle("br_after");

    // Load-use for LU cycles, then the same pattern against r0.
    set_load_use(5'd5);
    run_cycle("lu_hit");
    set_idle();
    for (int i = 0; i < LU; i++) run_cycle("lu_bubble");
    check("lu.stall_cnt", hz.stall_cycles, LU);
    set_load_use(5'd0);
    run_cycle("lu_r0");
    set_idle();

    // Branch and load-use together: the branch wins.
    set_load_use(5'd5);
    hz.exe_is_branch = 1; hz.z_flag = 1; tpc = 32'h0000_0100;
    run_cycle("br_vs_lu");
    set_idle();
    run_cycle("br_vs_lu_shadow");

    // Memory wait arriving during a branch shadow, then resuming it.
    hz.exe_is_branch = 1; hz.z_flag = 1; tpc = 32'h0000_0200;
    run_cycle("mw_br");
    set_idle();
    hz.mem_req = 1; hz.mem_ready = 0;
    for (int i = 0; i < 3; i++) run_cycle("mw_wait");
    hz.mem_ready = 1;
    run_cycle("mw_ready");
    set_idle();
    run_cycle("mw_resume_shadow");
    run_cycle("mw_run");

    // Memory wait over a load-use stall, released by dropping mem_req.
    set_load_use(5'd5);
    run_cycle("mw_lu_enter");
    set_idle();
    hz.mem_req = 1;
    run_cycle("mw_lu_wait");
    run_cycle("mw_lu_wait2");
    hz.mem_req = 0;
    run_cycle("mw_lu_drop");
    for (int i = 0; i < LU; i++) run_cycle("mw_lu_resume");

    // Saturation of the stall counter.
    hz.mem_req = 1; hz.mem_ready = 0;
    for (int i = 0; i < 20; i++) run_cycle("sat");
    check("sat.stall_cnt", hz.stall_cycles, CNT_MAX);
    set_idle();
    run_cycle("sat_release");

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(79) == 0) begin
        apply_reset("rnd_reset");
      end
      hz.dec_rs1       = 5'($urandom_range(3));
      hz.dec_rs2       = 5'($urandom_range(3));
      hz.dec_uses_rs1  = 1'($urandom_range(1));
      hz.dec_uses_rs2  = 1'($urandom_range(1));
      hz.exe_is_load   = 1'($urandom_range(1));
      hz.exe_rd        = 5'($urandom_range(3));
      hz.exe_is_branch = ($urandom_range(3) == 0);
      hz.z_flag        = 1'($urandom_range(1));
      tpc              = $urandom;
      hz.mem_req       = ($urandom_range(9) < 3);
      hz.mem_ready     = 1'($urandom_range(1));
      run_cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
